fpu_seq_param: RTL and testbench

- Parametrised, handshaked floating-point unit; successor to the single-precision top_FPU.
- Operand formats are generic (EXP_W/MAN_W).
- Uses a valid/ready input and output handshake, with an iterative mantissa datapath for mul/div.
- Adds IEEE special-value handling and sticky-free status flags.
- Sits between the operand register file and the writeback stage of the datapath.

---
 rtl/fpu_seq_param_if.sv | 27 ++
 rtl/fpu_seq_param.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fpu_seq_param.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_seq_param_if.sv
// rtl/fpu_seq_param_if.sv - operand/result handshake bundle for fpu_seq_param
interface fpu_seq_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [1:0]   operation;
    logic [W-1:0] a_fpn;
    logic [W-1:0] b_fpn;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;

    modport master (
        output in_valid, operation, a_fpn, b_fpn, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, operation, a_fpn, b_fpn, out_ready,
        output in_ready, out_valid, out, flags
    );
endinterface

// File: rtl/fpu_seq_param.sv
// rtl/fpu_seq_param.sv - handshaked parametrised FPU, iterative mul/div, truncating rounding
module fpu_seq_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           clk,
    input  logic           rst,
    fpu_seq_param_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int M    = MAN_W + 1;
    localparam int P    = 2 * M;
    localparam int EW   = EXP_W + 2;
    localparam int LZW  = $clog2(P) + 1;
    localparam int CW   = $clog2(M + 2) + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [3:0] F_INV = 4'b1000;
    localparam logic [3:0] F_DZ  = 4'b0100;
    localparam logic [3:0] F_OV  = 4'b0010;
    localparam logic [3:0] F_UF  = 4'b0001;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ADD, ITER, NORM, DONE} state_t;

    function automatic logic [W-1:0] inf_word(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [W-1:0] zero_word(input logic s);
        return {s, {(W-1){1'b0}}};
    endfunction

    state_t               state, next_state;
    logic                 in_ready_c, out_valid_c;

    logic [1:0]           op_r;
    logic [W-1:0]         a_r, b_r;
    logic [W-1:0]         out_r;
    logic [3:0]           flags_r;
    logic                 res_sign;
    logic signed [EW-1:0] exp_r;
    logic [M:0]           sum_r;
    logic [P-1:0]         prod_r, mcand_r;
    logic [M-1:0]         mplier_r, divisor_r;
    logic [M:0]           rem_r, quo_r;
    logic [CW-1:0]        cnt_r;

    logic                 sa, sb, sb_eff;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [M-1:0]         ma, mb;

    // Denormal inputs flush to signed zero by dropping the hidden bit.
    assign sa     = a_r[W-1];
    assign sb     = b_r[W-1];
    assign ea     = a_r[W-2 -: EXP_W];
    assign eb     = b_r[W-2 -: EXP_W];
    assign fa     = a_r[MAN_W-1:0];
    assign fb     = b_r[MAN_W-1:0];
    assign sb_eff = sb ^ (op_r == OP_SUB);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign ma     = a_zero ? '0 : {1'b1, fa};
    assign mb     = b_zero ? '0 : {1'b1, fb};

    logic         spec;
    logic [W-1:0] spec_word;
    logic [3:0]   spec_flags;

    always_comb begin
        spec       = 1'b0;
        spec_word  = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec = 1'b1; spec_word = QNAN; spec_flags = F_INV;
        end else begin
            case (op_r)
                OP_ADD, OP_SUB: begin
                    if (a_inf && b_inf && (sa != sb_eff)) begin
                        spec = 1'b1; spec_word = QNAN; spec_flags = F_INV;
                    end else if (a_inf) begin
                        spec = 1'b1; spec_word = inf_word(sa);
                    end else if (b_inf) begin
                        spec = 1'b1; spec_word = inf_word(sb_eff);
                    end
                end
                OP_MUL: begin
                    if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                        spec = 1'b1; spec_word = QNAN; spec_flags = F_INV;
                    end else if (a_inf || b_inf) begin
                        spec = 1'b1; spec_word = inf_word(sa ^ sb);
                    end else if (a_zero || b_zero) begin
                        spec = 1'b1; spec_word = zero_word(sa ^ sb);
                    end
                end
                default: begin
                    if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        spec = 1'b1; spec_word = QNAN; spec_flags = F_INV;
                    end else if (a_inf) begin
                        spec = 1'b1; spec_word = inf_word(sa ^ sb);
                    end else if (b_zero) begin
                        spec = 1'b1; spec_word = inf_word(sa ^ sb); spec_flags = F_DZ;
                    end else if (a_zero || b_inf) begin
                        spec = 1'b1; spec_word = zero_word(sa ^ sb);
                    end
                end
            endcase
        end
    end

    // Order operands by magnitude so the aligned difference is never negative.
    logic             swap, sx, sy, sign_c;
    logic [EXP_W-1:0] ex, ey, diff;
    logic [M-1:0]     mx, my, my_sh;
    logic [M:0]       sum_c;

    always_comb begin
        swap   = {eb, mb} > {ea, ma};
        ex     = swap ? eb : ea;
        ey     = swap ? ea : eb;
        mx     = swap ? mb : ma;
        my     = swap ? ma : mb;
        sx     = swap ? sb_eff : sa;
        sy     = swap ? sa : sb_eff;
        diff   = ex - ey;
        my_sh  = my >> diff;
        sum_c  = (sx == sy) ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});
        sign_c = ((sx != sy) && (sum_c == '0)) ? 1'b0 : sx;
    end

    logic                 rem_ge;
    assign rem_ge = (rem_r >= {1'b0, divisor_r});

    // Every source is placed so that exp_r describes a leading one at bit P-2.
    logic [P-1:0]         norm_in, norm_sh;
    logic [LZW-1:0]       lz;
    logic signed [EW-1:0] exp_n;
    logic [W-1:0]         norm_word;
    logic [3:0]           norm_flags;
    logic                 unused_norm;

    always_comb begin
        case (op_r)
            OP_MUL:  norm_in = prod_r;
            OP_DIV:  norm_in = {1'b0, quo_r, {(M-2){1'b0}}};
            default: norm_in = {sum_r, {(M-1){1'b0}}};
        endcase
        lz = '0;
        for (int i = 0; i < P; i++) begin
            if (norm_in[i]) lz = LZW'(P - 1 - i);
        end
        norm_sh    = norm_in << lz;
        exp_n      = exp_r + EW'(1) - EW'(lz);
        norm_word  = {res_sign, exp_n[EXP_W-1:0], norm_sh[P-2 -: MAN_W]};
        norm_flags = '0;
        if (norm_in == '0) begin
            norm_word = zero_word(res_sign);
        end else if (int'(exp_n) >= EMAX) begin
            norm_word = inf_word(res_sign); norm_flags = F_OV;
        end else if (int'(exp_n) <= 0) begin
            norm_word = zero_word(res_sign); norm_flags = F_UF;
        end
    end

    assign unused_norm = ^{norm_sh[P-1], norm_sh[M-2:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) next_state = PREP;
            end
            PREP: begin
                if (spec)          next_state = DONE;
                else if (!op_r[1]) next_state = ADD;
                else               next_state = ITER;
            end
            ADD:  next_state = NORM;
            ITER: if (cnt_r == CW'(1)) next_state = NORM;
            NORM: next_state = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_r   <= '0;
            flags_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_r    <= bus.operation;
                    a_r     <= bus.a_fpn;
                    b_r     <= bus.b_fpn;
                    flags_r <= '0;
                end
                PREP: begin
                    exp_r     <= (op_r == OP_MUL) ? EW'(ea) + EW'(eb) - EW'(BIAS)
                                                  : EW'(ea) - EW'(eb) + EW'(BIAS);
                    res_sign  <= sa ^ sb;
                    prod_r    <= '0;
                    mcand_r   <= {{M{1'b0}}, ma};
                    mplier_r  <= mb;
                    rem_r     <= {1'b0, ma};
                    divisor_r <= mb;
                    quo_r     <= '0;
                    cnt_r     <= (op_r == OP_MUL) ? CW'(M) : CW'(M + 1);
                    if (spec) begin
                        out_r   <= spec_word;
                        flags_r <= spec_flags;
                    end
                end
                ADD: begin
                    sum_r    <= sum_c;
                    res_sign <= sign_c;
                    exp_r    <= EW'(ex);
                end
                ITER: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (op_r == OP_MUL) begin
                        if (mplier_r[0]) prod_r <= prod_r + mcand_r;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                    end else begin
                        quo_r <= {quo_r[M-1:0], rem_ge};
                        rem_r <= (rem_ge ? (rem_r - {1'b0, divisor_r}) : rem_r) << 1;
                    end
                end
                NORM: begin
                    out_r   <= norm_word;
                    flags_r <= norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out       = out_r;
    assign bus.flags     = flags_r;
endmodule

// File: tb/tb_fpu_seq_param.sv
// tb/tb_fpu_seq_param.sv - directed self-checking bench for fpu_seq_param
module tb_fpu_seq_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    fpu_seq_param_if bus ();

    fpu_seq_param dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Drives one operation, scrambles the inputs after the accept edge, waits a bounded time for out_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit take, output logic [31:0] res, output logic [3:0] flg,
                          output int lat);
        @(negedge clk);
        bus.operation = op;
        bus.a_fpn     = a;
        bus.b_fpn     = b;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.operation = ~op;
        bus.a_fpn     = ~a;
        bus.b_fpn     = ~b;
        lat = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        res = bus.out;
        flg = bus.flags;
        if (take) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL reset out: got %h expected 00000000", bus.out); end
        n_checks++; if (bus.flags !== 4'h0) begin n_fail++; $display("FAIL reset flags: got %h expected 0", bus.flags); end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        logic [1:0] op; logic [31:0] a, b, y, res; logic [3:0] fl; int lat;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: begin op = 2'b00; a = 32'h41A00000; b = 32'h42C80000; y = 32'h42F00000; end
                1: begin op = 2'b01; a = 32'h41900000; b = 32'h40400000; y = 32'h41700000; end
                2: begin op = 2'b00; a = 32'hC1C80000; b = 32'h41880000; y = 32'hC1000000; end
                3: begin op = 2'b00; a = 32'hC1C80000; b = 32'hC1C80000; y = 32'hC2480000; end
                4: begin op = 2'b00; a = 32'h40A00000; b = 32'hC0A00000; y = 32'h00000000; end
                5: begin op = 2'b00; a = 32'h80000000; b = 32'h80000000; y = 32'h80000000; end
                default: begin op = 2'b00; a = 32'h00400000; b = 32'h3F800000; y = 32'h3F800000; end
            endcase
            run_op(op, a, b, 1'b1, res, fl, lat);
            n_checks++; if (res !== y) begin n_fail++; $display("FAIL add_sub[%0d] out: got %h expected %h", k, res, y); end
            n_checks++; if (fl !== 4'h0) begin n_fail++; $display("FAIL add_sub[%0d] flags: got %h expected 0", k, fl); end
            n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_sub[%0d] latency: got %0d expected 3", k, lat); end
        end
    endtask

    task automatic test_mul_div();
        logic [1:0] op; logic [31:0] a, b, y, res; logic [3:0] fl; int lat, el;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin op = 2'b10; a = 32'h41A00000; b = 32'h40900000; y = 32'h42B40000; el = 26; end
                1: begin op = 2'b11; a = 32'h41A00000; b = 32'h40C00000; y = 32'h40555555; el = 27; end
                2: begin op = 2'b10; a = 32'hC0400000; b = 32'h40000000; y = 32'hC0C00000; el = 26; end
                default: begin op = 2'b11; a = 32'h3F800000; b = 32'h40000000; y = 32'h3F000000; el = 27; end
            endcase
            run_op(op, a, b, 1'b1, res, fl, lat);
            n_checks++; if (res !== y) begin n_fail++; $display("FAIL mul_div[%0d] out: got %h expected %h", k, res, y); end
            n_checks++; if (fl !== 4'h0) begin n_fail++; $display("FAIL mul_div[%0d] flags: got %h expected 0", k, fl); end
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL mul_div[%0d] latency: got %0d expected %0d", k, lat, el); end
        end
    endtask

    task automatic test_specials();
        logic [1:0] op; logic [31:0] a, b, y, res; logic [3:0] f, fl; int lat; bit chk_lat;
        for (int k = 0; k < 8; k++) begin
            chk_lat = 1'b1;
            case (k)
                0: begin op = 2'b11; a = 32'h3F800000; b = 32'h00000000; y = 32'h7F800000; f = 4'b0100; end
                1: begin op = 2'b11; a = 32'h00000000; b = 32'h00000000; y = 32'h7FC00000; f = 4'b1000; end
                2: begin op = 2'b01; a = 32'h7F800000; b = 32'h7F800000; y = 32'h7FC00000; f = 4'b1000; end
                3: begin op = 2'b00; a = 32'h7FC00001; b = 32'h3F800000; y = 32'h7FC00000; f = 4'b1000; end
                4: begin op = 2'b10; a = 32'h80000000; b = 32'h40000000; y = 32'h80000000; f = 4'b0000; end
                5: begin op = 2'b00; a = 32'hFF800000; b = 32'h3F800000; y = 32'hFF800000; f = 4'b0000; end
                6: begin op = 2'b10; a = 32'h7F000000; b = 32'h40000000; y = 32'h7F800000; f = 4'b0010; chk_lat = 1'b0; end
                default: begin op = 2'b10; a = 32'h00800000; b = 32'h3F000000; y = 32'h00000000; f = 4'b0001; chk_lat = 1'b0; end
            endcase
            run_op(op, a, b, 1'b1, res, fl, lat);
            n_checks++; if (res !== y) begin n_fail++; $display("FAIL special[%0d] out: got %h expected %h", k, res, y); end
            n_checks++; if (fl !== f) begin n_fail++; $display("FAIL special[%0d] flags: got %b expected %b", k, fl, f); end
            n_checks++;
            if (chk_lat && lat !== 1) begin n_fail++; $display("FAIL special[%0d] latency: got %0d expected 1", k, lat); end
            else if (!chk_lat && lat < 1) begin n_fail++; $display("FAIL special[%0d] timeout: got %0d expected >0", k, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res; logic [3:0] fl; int lat;
        run_op(2'b00, 32'h41A00000, 32'h42C80000, 1'b0, res, fl, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp first latency: got %0d expected 3", lat); end
        for (int c = 0; c < 10; c++) begin
            bus.in_valid  = c[0];
            bus.operation = 2'b10;
            bus.a_fpn     = 32'h40400000;
            bus.b_fpn     = 32'h40400000;
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== 32'h42F00000 || bus.flags !== 4'h0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp hold[%0d]: got v=%b out=%h fl=%h rdy=%b expected v=1 out=42f00000 fl=0 rdy=0",
                         c, bus.out_valid, bus.out, bus.flags, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp release: got rdy=%b v=%b expected rdy=1 v=0", bus.in_ready, bus.out_valid);
        end
        run_op(2'b10, 32'h41A00000, 32'h40900000, 1'b1, res, fl, lat);
        n_checks++; if (res !== 32'h42B40000) begin n_fail++; $display("FAIL bp next out: got %h expected 42b40000", res); end
        n_checks++; if (lat !== 26) begin n_fail++; $display("FAIL bp next latency: got %0d expected 26", lat); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] res; logic [3:0] fl; int lat; bit seen;
        @(negedge clk);
        bus.operation = 2'b11;
        bus.a_fpn     = 32'h41A00000;
        bus.b_fpn     = 32'h40C00000;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL abort out: got %h expected 00000000", bus.out); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort in_ready: got %b expected 1", bus.in_ready); end
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort stray result: got out_valid=1 expected 0"); end
        run_op(2'b00, 32'h41A00000, 32'h42C80000, 1'b1, res, fl, lat);
        n_checks++; if (res !== 32'h42F00000) begin n_fail++; $display("FAIL abort next out: got %h expected 42f00000", res); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL abort next latency: got %0d expected 3", lat); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.operation = 2'b00;
        bus.a_fpn     = '0;
        bus.b_fpn     = '0;
        test_reset();
        test_add_sub();
        test_mul_div();
        test_specials();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
